multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//   Multicycle control sequencer for the MIPS datapath. Splits each instruction into
//   FETCH/DECODE/EXEC/MEM/WB steps. Generates per-step datapath strobes and mux selects.
//   Stalls on a memory ready handshake and vectors external interrupts between instructions.
//   Replaces single-cycle opcode decode when PC, IR, register file and main memory share one clock.
// PARAMETERS
//   MEM_TIMEOUT  15        cycles a memory state may wait for mem_ready before a fault (1..255)
//   IRQ_SEL      2'b11     pc_source code that selects the interrupt vector
// PORTS
//   clock        in   1  system clock; all state changes on the rising edge
//   reset        in   1  synchronous reset, active-low
//   opcode       in   6  IR[31:26]; valid from DECODE onward
//   zero         in   1  ALU zero flag; used in BRANCH
//   mem_ready    in   1  memory has completed the current read/write this cycle
//   interrupt    in   1  level interrupt request
//   pc_write     out  1  unconditional PC load
//   pc_write_cond out 1  PC load if zero (branch)
//   i_or_d       out  1  memory address: 0=PC, 1=ALUOut
//   mem_read     out  1  memory read strobe
//   mem_write    out  1  memory write strobe
//   ir_write     out  1  IR load
//   mem_to_reg   out  1  register write data: 0=ALUOut, 1=MDR
//   reg_dst      out  1  destination register: 0=rt, 1=rd
//   reg_write    out  1  register file write enable
//   alu_src_a    out  1  ALU A input: 0=PC, 1=rs
//   alu_src_b    out  2  ALU B input: 00=rt, 01=const 1, 10=sign-ext imm, 11=imm shifted
//   alu_op       out  2  00=add, 01=sub, 10=funct-decoded
//   pc_source    out  2  00=ALU, 01=ALUOut, 10=jump target, IRQ_SEL=vector
//   irq_ack      out  1  one-cycle pulse when the interrupt is taken
//   fault        out  1  sticky: illegal opcode or memory timeout
//   state        out  4  current state code, for the 7-seg debug display
// BEHAVIOUR
//   State encoding: FETCH=0, DECODE=1, MADDR=2, MRD=3, MWB=4, MWR=5, REXE=6, RWB=7,
//     BRANCH=8, JUMP=9, IEXE=10, IWB=11, IRQ=12, HALT=15.
//   Reset (reset==0 at an edge): state<=FETCH, fault<=0, wait counter<=0.
//     While reset is low, every strobe, irq_ack and pc_write* is forced to 0.
//   Outputs are a Moore decode of state. Exception: in FETCH, ir_write and pc_write equal mem_ready (Mealy).
//   Outputs not listed for a state are 0.
//   FETCH
//     mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
//     If mem_ready, go to DECODE; otherwise stay.
//   DECODE
//     alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
//     Next state by opcode: 000000->REXE, 100011/101011->MADDR, 000100->BRANCH,
//     000010->JUMP, 001000->IEXE, any other->HALT with fault<=1.
//   MADDR
//     alu_src_a=1, alu_src_b=10, alu_op=00.
//     Next: MRD if lw, MWR if sw.
//   MRD
//     mem_read=1, i_or_d=1. Stay until mem_ready, then go to MWB.
//   MWB
//     reg_write=1, mem_to_reg=1, reg_dst=0. Instruction ends.
//   MWR
//     mem_write=1, i_or_d=1. Stay until mem_ready; the instruction ends on mem_ready.
//   REXE
//     alu_src_a=1, alu_src_b=00, alu_op=10. Go to RWB.
//   RWB
//     reg_write=1, reg_dst=1, mem_to_reg=0. Instruction ends.
//   IEXE
//     alu_src_a=1, alu_src_b=10, alu_op=00. Go to IWB.
//   IWB
//     reg_write=1, reg_dst=0, mem_to_reg=0. Instruction ends.
//   BRANCH
//     alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Instruction ends.
//   JUMP
//     pc_write=1, pc_source=10. Instruction ends.
//   Instruction end
//     Next state is IRQ if interrupt==1 on that edge, else FETCH.
//     Interrupts are never taken mid-instruction.
//   IRQ
//     pc_write=1, pc_source=IRQ_SEL, irq_ack=1 for exactly one cycle, then FETCH.
//     Interrupt must be deasserted by software/handler; a still-high level re-enters IRQ
//     at the next instruction end.
//   Memory timeout
//     An 8-bit wait counter clears on entry to FETCH, MRD or MWR.
//     It increments each cycle spent in one of those states with mem_ready==0.
//     If it reaches MEM_TIMEOUT, go to HALT and set fault<=1. No strobes are issued
//     that cycle beyond the state's own.
//   HALT
//     All strobes 0, state=15. Exits only via reset.
//   Reset mid-operation: an in-progress memory access is abandoned. mem_read/mem_write
//     drop in the reset cycle and no register or PC write occurs.
// TESTING
//   1. Reset low 2 cycles, release, mem_ready=1 always -> state 0, pc_write=ir_write=1
//      in cycle 1, DECODE next.
//   2. R-type (opcode 0), mem_ready=1 -> states 0,1,6,7,0; reg_write=1 and reg_dst=1
//      only in state 7; 4 cycles per instruction.
//   3. lw with mem_ready low 3 cycles in MRD -> states 0,1,2,3,3,3,3,4,0;
//      mem_read held high in all MRD cycles.
//   4. beq with zero=1, then zero=0 -> pc_write_cond=1 in state 8 both times,
//      pc_source=01; next state 0.
//   5. interrupt=1 raised during REXE -> RWB completes, then IRQ for 1 cycle
//      (irq_ack=1, pc_source=11), then FETCH.
//   6. Opcode 6'b111111 -> HALT, fault=1. Separately, mem_ready held 0 in FETCH for
//      15 cycles -> HALT, fault=1. Reset clears both.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS control sequencer: steps each instruction through FETCH..WB,
// decodes per-state datapath strobes, stalls on mem_ready and vectors interrupts.
module multicycle_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter logic [1:0]  IRQ_SEL     = 2'b11
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  input  logic       interrupt,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       irq_ack,
  output logic       fault,
  output logic [3:0] state
);

  localparam int unsigned CNT_W = 8;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MADDR  = 4'd2,
    S_MRD    = 4'd3,
    S_MWB    = 4'd4,
    S_MWR    = 4'd5,
    S_REXE   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXE   = 4'd10,
    S_IWB    = 4'd11,
    S_IRQ    = 4'd12,
    S_HALT   = 4'd15
  } state_e;

  state_e           state_q, state_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             instr_end;
  logic             waiting;

  // The branch decision itself is made in the datapath via pc_write_cond.
  logic unused_zero;
  assign unused_zero = zero;

  // State, sticky fault and memory wait counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_FETCH;
      fault_q    <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fault_q    <= fault_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d       = state_q;
    fault_d       = fault_q;
    wait_cnt_d    = wait_cnt_q;
    instr_end     = 1'b0;
    waiting       = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    irq_ack       = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
        else           waiting = 1'b1;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:     state_d = S_REXE;
          OP_LW, OP_SW: state_d = S_MADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_IEXE;
          default: begin
            state_d = S_HALT;
            fault_d = 1'b1;
          end
        endcase
      end
      S_MADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? S_MWR : S_MRD;
      end
      S_MRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = S_MWB;
        else           waiting = 1'b1;
      end
      S_MWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_end  = 1'b1;
      end
      S_MWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) instr_end = 1'b1;
        else           waiting   = 1'b1;
      end
      S_REXE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_RWB;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        instr_end = 1'b1;
      end
      S_IEXE: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_IWB;
      end
      S_IWB: begin
        reg_write = 1'b1;
        instr_end = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_end     = 1'b1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        instr_end = 1'b1;
      end
      S_IRQ: begin
        pc_write  = 1'b1;
        pc_source = IRQ_SEL;
        irq_ack   = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: begin
        state_d = S_HALT;
        fault_d = 1'b1;
      end
    endcase

    // Interrupts are only sampled on the last cycle of an instruction.
    if (instr_end) state_d = interrupt ? S_IRQ : S_FETCH;

    if (waiting) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
      if (wait_cnt_d == CNT_W'(MEM_TIMEOUT)) begin
        state_d = S_HALT;
        fault_d = 1'b1;
      end
    end

    // Counter restarts whenever a memory-waiting state is freshly entered.
    if (state_d != state_q) wait_cnt_d = '0;

    if (!reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      irq_ack       = 1'b0;
    end
  end

  assign fault = fault_q;
  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized bench for multicycle_ctrl_fsm: builds the expected state trace per
// instruction and checks state, strobes and fault every cycle.
module tb_multicycle_ctrl_fsm;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  logic       clock;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       interrupt;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, irq_ack, fault;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  int   total = 0;
  int   bad   = 0;
  logic exp_fault = 1'b0;

  logic [16:0] obs;
  logic [6:0]  strobes;
  assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_source, irq_ack};
  assign strobes = {pc_write, pc_write_cond, mem_read, mem_write, ir_write,
                    reg_write, irq_ack};

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(15), .IRQ_SEL(2'b11)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .interrupt(interrupt),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .irq_ack(irq_ack), .fault(fault), .state(state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Output table of each state, straight from the state descriptions.
  function automatic logic [16:0] exp_out(input logic [3:0] st, input logic rdy);
    logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, ack;
    logic [1:0] asb, aop, ps;
    {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, ack} = '0;
    asb = 2'b00; aop = 2'b00; ps = 2'b00;
    case (st)
      4'd0:  begin mr = 1; asb = 2'b01; pw = rdy; irw = rdy; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin mr = 1; iod = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mw = 1; iod = 1; end
      4'd6:  begin asa = 1; aop = 2'b10; end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
      4'd9:  begin pw = 1; ps = 2'b10; end
      4'd10: begin asa = 1; asb = 2'b10; end
      4'd11: rw = 1;
      4'd12: begin pw = 1; ps = 2'b11; ack = 1; end
      default: ;
    endcase
    return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ps, ack};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic mid(input bit force_irq, input bit late);
    return force_irq ? late : rb();
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // One clock cycle: drive inputs, check the cycle's outputs, advance.
  task automatic cyc(input logic [3:0] st, input logic rdy, input logic irq,
                     input logic [5:0] opc);
    mem_ready = rdy; interrupt = irq; opcode = opc; zero = rb();
    #1;
    chk($sformatf("state_s%0d", st), 32'(state), 32'(st));
    chk($sformatf("out_s%0d", st), 32'(obs), 32'(exp_out(st, rdy)));
    chk($sformatf("fault_s%0d", st), 32'(fault), 32'(exp_fault));
    @(posedge clock); #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0; mem_ready = 1'b1; interrupt = 1'b1;
    #1;
    chk("rst_strobes0", 32'(strobes), 32'd0);
    @(posedge clock); #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_strobes1", 32'(strobes), 32'd0);
    @(posedge clock); #1;
    reset = 1'b1; interrupt = 1'b0; exp_fault = 1'b0;
  endtask

  // Expected state trace of one legal instruction with random memory stalls.
  task automatic run_instr(input logic [5:0] opc, input bit force_irq);
    int n;
    logic irq_end;
    logic [3:0] end_st;
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) cyc(4'd0, 1'b0, mid(force_irq, 0), 6'($urandom));
    cyc(4'd0, 1'b1, mid(force_irq, 0), 6'($urandom));
    cyc(4'd1, rb(), mid(force_irq, 0), opc);
    irq_end = force_irq ? 1'b1 : ($urandom_range(0, 3) == 0);
    end_st = 4'd15;
    case (opc)
      OP_R:    begin cyc(4'd6, rb(), mid(force_irq, 1), opc); end_st = 4'd7; end
      OP_ADDI: begin cyc(4'd10, rb(), mid(force_irq, 1), opc); end_st = 4'd11; end
      OP_BEQ:  end_st = 4'd8;
      OP_J:    end_st = 4'd9;
      OP_LW: begin
        cyc(4'd2, rb(), mid(force_irq, 1), opc);
        n = $urandom_range(0, 4);
        for (int i = 0; i < n; i++) cyc(4'd3, 1'b0, mid(force_irq, 1), opc);
        cyc(4'd3, 1'b1, mid(force_irq, 1), opc);
        end_st = 4'd4;
      end
      OP_SW: begin
        cyc(4'd2, rb(), mid(force_irq, 1), opc);
        n = $urandom_range(0, 4);
        for (int i = 0; i < n; i++) cyc(4'd5, 1'b0, mid(force_irq, 1), opc);
        end_st = 4'd5;
      end
      default: ;
    endcase
    cyc(end_st, (opc == OP_SW) ? 1'b1 : rb(), irq_end, opc);
    if (irq_end) cyc(4'd12, rb(), 1'b0, opc);
  endtask

  initial begin
    logic [5:0] legal [6];
    legal[0] = OP_R;   legal[1] = OP_LW; legal[2] = OP_SW;
    legal[3] = OP_BEQ; legal[4] = OP_J;  legal[5] = OP_ADDI;
    reset = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b1; interrupt = 1'b0;

    apply_reset();

    // Each instruction class once, then an interrupt raised during REXE.
    for (int i = 0; i < 6; i++) run_instr(legal[i], 1'b0);
    run_instr(OP_BEQ, 1'b0);
    run_instr(OP_R, 1'b1);

    for (int i = 0; i < 40; i++) run_instr(legal[$urandom_range(0, 5)], 1'b0);

    // Illegal opcode halts with fault until reset.
    cyc(4'd0, 1'b1, 1'b0, 6'($urandom));
    cyc(4'd1, rb(), 1'b0, 6'b111111);
    exp_fault = 1'b1;
    for (int i = 0; i < 3; i++) cyc(4'd15, rb(), rb(), 6'($urandom));
    apply_reset();

    // Fetch never completes: fifteenth stalled cycle trips the timeout.
    for (int i = 0; i < 15; i++) cyc(4'd0, 1'b0, rb(), 6'($urandom));
    exp_fault = 1'b1;
    for (int i = 0; i < 2; i++) cyc(4'd15, rb(), rb(), 6'($urandom));
    apply_reset();

    // Reset arriving while a load is stalled in MRD.
    cyc(4'd0, 1'b1, 1'b0, 6'($urandom));
    cyc(4'd1, 1'b0, 1'b0, OP_LW);
    cyc(4'd2, 1'b0, 1'b0, OP_LW);
    cyc(4'd3, 1'b0, 1'b0, OP_LW);
    cyc(4'd3, 1'b0, 1'b0, OP_LW);
    apply_reset();
    run_instr(OP_SW, 1'b0);
    run_instr(OP_LW, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
